// File: rtl/axi_wr_slave.sv
// AXI write-channel slave: accepts one write burst at a time, streams the beats
// into a word-addressed SRAM write port, and returns a single B response.
module axi_wr_slave #(
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        AWID_S,
  input  logic [31:0]       AWADDR_S,
  input  logic [3:0]        AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  input  logic [31:0]       WDATA_S,
  input  logic [3:0]        WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  output logic [7:0]        BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'h0;
  localparam logic [1:0] RESP_SLVERR = 2'h2;

  state_t      r_state;
  logic [7:0]  r_id;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic [1:0]  r_burst;
  logic        r_cap_err;
  logic        r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_last_beat;
  logic w_bad_req;
  logic w_unused_ok;

  assign w_aw_hs     = AWVALID_S && (r_state == IDLE);
  assign w_w_hs      = WVALID_S && (r_state == DATA);
  assign w_last_beat = (r_cnt == r_len);
  assign w_bad_req   = ((AWBURST_S != BURST_FIXED) && (AWBURST_S != BURST_INCR))
                       || (AWSIZE_S > 3'b010);

  // Only the word-address window of the running byte address reaches the memory.
  assign w_unused_ok = ^{AWADDR_S[31:MEM_AW+2], r_addr[31:MEM_AW+2], r_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_cap_err <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_id      <= AWID_S;
            r_addr    <= AWADDR_S;
            r_len     <= AWLEN_S;
            r_burst   <= AWBURST_S;
            r_cnt     <= '0;
            r_cap_err <= w_bad_req;
            r_err     <= w_bad_req;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_w_hs) begin
            if (r_burst == BURST_INCR) begin
              r_addr <= r_addr + 32'd4;
            end
            r_cnt <= r_cnt + 4'd1;
            // WLAST only flags an error; the beat count alone ends the burst.
            if (WLAST_S != w_last_beat) begin
              r_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          if (BREADY_S) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign AWREADY_S = (r_state == IDLE);
  assign WREADY_S  = (r_state == DATA);
  assign BVALID_S  = (r_state == RESP);
  assign BID_S     = r_id;
  assign BRESP_S   = ((r_state == RESP) && r_err) ? RESP_SLVERR : RESP_OKAY;

  // Requests rejected at capture still drain their beats, but never write.
  assign mem_en    = w_w_hs && !r_cap_err;
  assign mem_we    = mem_en ? WSTRB_S : '0;
  assign mem_addr  = r_addr[MEM_AW+1:2];
  assign mem_wdata = WDATA_S;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: a transaction-level model predicts every
// memory beat and B response, and a per-cycle compare process checks the DUT.
module tb_axi_wr_slave;

  localparam int unsigned MEM_AW = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        AWID_S = '0;
  logic [31:0]       AWADDR_S = '0;
  logic [3:0]        AWLEN_S = '0;
  logic [2:0]        AWSIZE_S = '0;
  logic [1:0]        AWBURST_S = '0;
  logic              AWVALID_S = 1'b0;
  logic              AWREADY_S;
  logic [31:0]       WDATA_S = '0;
  logic [3:0]        WSTRB_S = '0;
  logic              WLAST_S = 1'b0;
  logic              WVALID_S = 1'b0;
  logic              WREADY_S;
  logic [7:0]        BID_S;
  logic [1:0]        BRESP_S;
  logic              BVALID_S;
  logic              BREADY_S = 1'b1;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  axi_wr_slave #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                en;
    logic [MEM_AW-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       data;
  } beat_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } rsp_t;

  beat_t             exp_beats[$];
  rsp_t              exp_rsp[$];
  logic [MEM_AW-1:0] obs_addr[$];
  int aw_cyc = 0;
  int wr_cyc = 0;
  int bv_cyc = 0;
  bit prev_bv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] base, input int i);
    return base + 32'(i) * 32'h1111_1111;
  endfunction

  // Transaction-level prediction straight from the protocol rules.
  task automatic model_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] base, input logic [3:0] strb,
                           input logic [15:0] lastmask);
    bit    cap_err;
    bit    err;
    beat_t b;
    rsp_t  r;
    logic [31:0] a;
    cap_err = (burst > 2'b01) || (size > 3'd2);
    err = cap_err;
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == 2'b01) ? addr + 32'(4 * i) : addr;
      b.en   = !cap_err;
      b.addr = a[MEM_AW+1:2];
      b.we   = strb;
      b.data = beat_data(base, i);
      exp_beats.push_back(b);
      if (lastmask[i] != (i == int'(len))) err = 1'b1;
    end
    r.id   = id;
    r.resp = err ? 2'h2 : 2'h0;
    exp_rsp.push_back(r);
  endtask

  task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWSIZE_S = size; AWBURST_S = burst;
    AWVALID_S = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (AWREADY_S) begin ok = 1'b1; break; end
    end
    if (!ok) chk("aw_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 AWVALID_S = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 1'b0;
    WDATA_S = data; WSTRB_S = strb; WLAST_S = last; WVALID_S = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (WREADY_S) begin ok = 1'b1; break; end
    end
    if (!ok) chk("w_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 WVALID_S = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] base, input logic [3:0] strb,
                           input logic [15:0] lastmask, input int stall_after, input int stall_cyc);
    model_txn(id, addr, len, size, burst, base, strb, lastmask);
    aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      w_beat(beat_data(base, i), strb, lastmask[i]);
      if (i == stall_after) begin
        repeat (stall_cyc) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (AWREADY_S && exp_rsp.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      prev_bv = 1'b0;
      chk("reset_outputs",
          {AWREADY_S, WREADY_S, BVALID_S, BID_S, BRESP_S, mem_en, mem_we, mem_addr},
          {1'b1, 1'b0, 1'b0, 8'h00, 2'h0, 1'b0, 4'h0, 14'h0});
    end else begin
      if (AWVALID_S && AWREADY_S) aw_cyc = cyc;
      chk("ready_exclusive", 32'(AWREADY_S && WREADY_S), 32'd0);
      if (WVALID_S && WREADY_S) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = exp_beats.pop_front();
          chk("mem_en", 32'(mem_en), 32'(b.en));
          if (b.en) begin
            chk("mem_addr", 32'(mem_addr), 32'(b.addr));
            chk("mem_we", 32'(mem_we), 32'(b.we));
            chk("mem_wdata", mem_wdata, b.data);
          end else begin
            chk("mem_we_blocked", 32'(mem_we), 32'd0);
          end
        end
        if (mem_en) begin
          wr_cyc = cyc;
          obs_addr.push_back(mem_addr);
        end
      end else begin
        chk("no_write_without_beat", {27'd0, mem_en, mem_we}, 32'd0);
      end
      if (BVALID_S) begin
        if (!prev_bv) bv_cyc = cyc;
        chk("awready_in_resp", 32'(AWREADY_S), 32'd0);
        if (exp_rsp.size() == 0) begin
          chk("unexpected_bvalid", 32'd1, 32'd0);
        end else begin
          chk("bid", 32'(BID_S), 32'(exp_rsp[0].id));
          chk("bresp", 32'(BRESP_S), 32'(exp_rsp[0].resp));
          if (BREADY_S) void'(exp_rsp.pop_front());
        end
      end
      prev_bv = BVALID_S;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single-beat INCR, latency pinned by hand.
    obs_addr.delete();
    run_burst(8'h5A, 32'h0000_0010, 4'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 16'h0001, -1, 0);
    wait_idle();
    chk("t1_write_latency", 32'(wr_cyc - aw_cyc), 32'd1);
    chk("t1_bvalid_latency", 32'(bv_cyc - aw_cyc), 32'd2);
    chk("t1_nwrites", 32'(obs_addr.size()), 32'd1);
    if (obs_addr.size() > 0) chk("t1_addr", 32'(obs_addr[0]), 32'h4);

    // 4-beat INCR wrapping the 14-bit word space, 2-cycle stall after beat 2.
    obs_addr.delete();
    run_burst(8'h21, 32'h0000_FFF8, 4'd3, 3'd2, 2'b01, 32'h1000_0000, 4'hF, 16'h0008, 1, 2);
    wait_idle();
    chk("t2_nwrites", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("t2_addr0", 32'(obs_addr[0]), 32'h3FFE);
      chk("t2_addr1", 32'(obs_addr[1]), 32'h3FFF);
      chk("t2_addr2", 32'(obs_addr[2]), 32'h0000);
      chk("t2_addr3", 32'(obs_addr[3]), 32'h0001);
    end

    // FIXED burst: every beat at the same word.
    obs_addr.delete();
    run_burst(8'h33, 32'h0000_0100, 4'd2, 3'd2, 2'b00, 32'h2000_0000, 4'b0011, 16'h0004, -1, 0);
    wait_idle();
    chk("t3_nwrites", 32'(obs_addr.size()), 32'd3);
    foreach (obs_addr[i]) chk("t3_addr", 32'(obs_addr[i]), 32'h40);

    // Early WLAST: all four beats still written, SLVERR.
    obs_addr.delete();
    run_burst(8'h44, 32'h0000_0200, 4'd3, 3'd2, 2'b01, 32'h3000_0000, 4'hF, 16'h0009, -1, 0);
    wait_idle();
    chk("t4_nwrites", 32'(obs_addr.size()), 32'd4);

    // W presented in IDLE waits for the address.
    WDATA_S = 32'hCAFE_0001; WSTRB_S = 4'hF; WLAST_S = 1'b1; WVALID_S = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_wready_idle", 32'(WREADY_S), 32'd0);
      chk("t5_mem_en_idle", 32'(mem_en), 32'd0);
    end
    @(posedge clk); #1;
    run_burst(8'h55, 32'h0000_0300, 4'd0, 3'd2, 2'b01, 32'hCAFE_0001, 4'hF, 16'h0001, -1, 0);
    wait_idle();

    // WRAP rejected: beats drained without writes, response held with BREADY low.
    obs_addr.delete();
    BREADY_S = 1'b0;
    run_burst(8'hC3, 32'h0000_0400, 4'd1, 3'd2, 2'b10, 32'h4000_0000, 4'hF, 16'h0002, -1, 0);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (BVALID_S) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t6_bvalid_seen", 32'(ok), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("t6_hold", {20'd0, BVALID_S, AWREADY_S, BID_S, BRESP_S}, {20'd0, 1'b1, 1'b0, 8'hC3, 2'h2});
    end
    @(posedge clk);
    #1 BREADY_S = 1'b1;
    wait_idle();
    chk("t6_no_writes", 32'(obs_addr.size()), 32'd0);

    // Oversized beat rejected.
    obs_addr.delete();
    run_burst(8'h66, 32'h0000_0500, 4'd0, 3'd3, 2'b01, 32'h5000_0000, 4'hF, 16'h0001, -1, 0);
    wait_idle();
    chk("t7_no_writes", 32'(obs_addr.size()), 32'd0);

    // Reset during beat 2 of a 4-beat burst.
    model_txn(8'h77, 32'h0000_0600, 4'd3, 3'd2, 2'b01, 32'h6000_0000, 4'hF, 16'h0008);
    aw(8'h77, 32'h0000_0600, 4'd3, 3'd2, 2'b01);
    w_beat(beat_data(32'h6000_0000, 0), 4'hF, 1'b0);
    WDATA_S = beat_data(32'h6000_0000, 1); WLAST_S = 1'b0; WVALID_S = 1'b1;
    #1 chk("t8_mem_en_before_rst", 32'(mem_en), 32'd1);
    #1;
    exp_beats.delete();
    exp_rsp.delete();
    rst = 1'b0;
    #1;
    chk("t8_rst_outputs", {AWREADY_S, WREADY_S, BVALID_S, BID_S, BRESP_S, mem_en, mem_we, mem_addr},
        {1'b1, 1'b0, 1'b0, 8'h00, 2'h0, 1'b0, 4'h0, 14'h0});
    WVALID_S = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    run_burst(8'h88, 32'h0000_0010, 4'd0, 3'd2, 2'b01, 32'h7000_0000, 4'hF, 16'h0001, -1, 0);
    wait_idle();
    chk("beats_drained", 32'(exp_beats.size()), 32'd0);
    chk("rsps_drained", 32'(exp_rsp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave.md
# axi_wr_slave

Slave-side AXI write responder. It terminates one interconnect slave port: it accepts a write address, sinks the write data beats into a word-addressed SRAM-style memory port, and returns the write response. It is the far end of the write-address path leaving the interconnect's AW arbitration and decode stage. It handles one outstanding transaction at a time.

## Interface
- MEM_AW, 14, memory word-address width; mem_addr = byte address bits [MEM_AW+1:2]
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately)
- AWID_S  in  8  (`AXI_IDS_BITS`) write transaction ID
- AWADDR_S  in  32  start byte address
- AWLEN_S  in  4  beats minus one
- AWSIZE_S  in  3  beat size
- AWBURST_S  in  2  burst type
- AWVALID_S  in  1  address valid
- AWREADY_S  out  1  address ready
- WDATA_S  in  32  write data
- WSTRB_S  in  4  byte strobes
- WLAST_S  in  1  final-beat marker
- WVALID_S  in  1  data valid
- WREADY_S  out  1  data ready
- BID_S  out  8  response ID
- BRESP_S  out  2  response code, OKAY=2'h0, SLVERR=2'h2
- BVALID_S  out  1  response valid
- BREADY_S  in  1  response ready
- mem_en  out  1  memory write enable for this cycle
- mem_we  out  4  per-byte write enables, active-high
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32  write data

## Operation
- FSM states: IDLE, DATA, RESP. Reset state is IDLE.
- IDLE: AWREADY_S=1 and WREADY_S=0.
  - On AWVALID_S&&AWREADY_S, capture AWID_S, AWADDR_S, AWLEN_S and AWBURST_S; clear the beat counter and the error flag; go to DATA.
  - Set the error flag at capture if AWBURST_S is not FIXED (2'b00) or INCR (2'b01), or if AWSIZE_S > 3'b010.
- DATA: WREADY_S=1 and AWREADY_S=0.
  - Each W handshake performs a memory write in the same cycle: mem_en=1, mem_we=WSTRB_S, mem_addr=addr_reg[MEM_AW+1:2], mem_wdata=WDATA_S.
  - If the error flag was set at capture, the beats are still accepted but mem_en=0 (nothing is written).
  - After each beat, addr_reg += 4 for INCR and holds for FIXED. The add is 32-bit modulo 2^32. mem_addr wraps modulo 2^MEM_AW.
  - The beat counter is 4 bits. The burst always ends after exactly AWLEN_S+1 beats. WLAST_S never terminates it early.
  - WLAST_S mismatch sets the error flag: WLAST_S=1 on a non-final beat, or WLAST_S=0 on the final beat. Writes already performed are not undone.
  - Final beat handshake: go to RESP.
- RESP: BVALID_S=1, BID_S=captured ID, BRESP_S=SLVERR if the error flag is set, else OKAY. BID_S and BRESP_S are held stable until BVALID_S&&BREADY_S, then return to IDLE.
- mem_en=0 and mem_we=0 in every cycle without a W handshake.
- mem_wdata is driven by WDATA_S at all times. Its value is don't-care when mem_en=0.

## Timing
- Outputs while rst=0 or just after release: state IDLE; AWREADY_S=1, WREADY_S=0, BVALID_S=0, BID_S=0, BRESP_S=0, mem_en=0, mem_we=0, mem_addr=0.
- AWREADY_S, WREADY_S and BVALID_S are decoded from registered state only, with no combinational path from the VALID inputs.
- mem_en and mem_we are combinational from WVALID_S and state. The memory samples them on the same edge that completes the handshake.
- Latency for an N-beat burst with VALIDs held high and no stalls:
  - AW handshake at cycle 0.
  - Beats at cycles 1..N.
  - BVALID_S high from cycle N+1.
  - With BREADY_S=1, back in IDLE at N+2. The next AW can complete at cycle N+2.
- A W beat presented during IDLE waits, not accepted, until DATA.
- WVALID_S low stalls the burst; the counter and address hold.
- BREADY_S low holds RESP indefinitely; AWREADY_S stays 0.
- Reset asserted mid-burst or mid-response: the transaction is abandoned immediately. All outputs take their reset values; mem_en drops asynchronously. No response is issued.

## Test plan
- Single beat INCR: AWADDR=0x0000_0010, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 -> mem write addr 4, we=4'hF in cycle 1; BVALID cycle 2, BRESP=OKAY, BID=AWID.
- 4-beat INCR from 0x0000_FFF8, MEM_AW=14, with WVALID low for 2 cycles between beats 2 and 3 -> mem_addr 0x3FFE, 0x3FFF, 0x0000, 0x0001 (wrap); no write during the stall; OKAY.
- FIXED burst AWLEN=2, WSTRB=4'b0011 -> three writes, all at the same mem_addr, we=4'b0011.
- WLAST=1 on beat 1 of AWLEN=3 -> still 4 beats accepted and written; BRESP=SLVERR.
- AWBURST=2'b10 (WRAP), AWLEN=1 -> 2 beats accepted, mem_en never 1, SLVERR. Then BREADY held low 5 cycles -> BVALID, BID and BRESP stable and AWREADY=0 throughout.
- rst pulled low during beat 2 of a 4-beat burst -> mem_en=0 and outputs at reset values at once. After release, a new single-beat write completes with OKAY.
